phy_tx_lane_scheduler: RTL and testbench
========================================

PHY_TX_LANE_SCHEDULER -- requirements
Module: phy_tx_lane_scheduler

Interface
REQ-001 Parameter TRAIN_LEN, default 4: number of consecutive idle (comma) bytes sent in TRAIN before entering RUN.
REQ-002 Parameter IDLE_BYTE, default 8'hBC: comma byte driven whenever no data byte is sent.
REQ-003 clk_4f  input  1  byte clock; the block's only clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 link_active  input  1  high when the receiver side has achieved comma lock and the link may carry data.
REQ-006 valid_in0..valid_in3  input  1 each  requester i holds a byte.
REQ-007 data_in0..data_in3  input  8 each  byte offered by requester i.
REQ-008 ready_out0..ready_out3  output  1 each  requester i's byte is consumed this cycle; combinational, at most one high per cycle.
REQ-009 data_out  output  8  byte toward the parallel-to-serial stage; registered.
REQ-010 valid_out  output  1  data_out carries requester data (0 = idle comma); registered.
REQ-011 lane_out  output  2  index of the requester whose byte is in data_out; registered; 0 when valid_out=0.
REQ-012 in_run  output  1  high while the FSM is in RUN; registered.

Function
REQ-013 FSM states: TRAIN, RUN.
REQ-014 TRAIN: data_out=IDLE_BYTE, valid_out=0, all ready_out low; train_cnt increments each cycle while link_active=1 and clears to 0 whenever link_active=0.
REQ-015 TRAIN->RUN on the cycle train_cnt reaches TRAIN_LEN-1 with link_active=1; the first grant is possible in the first RUN cycle.
REQ-016 RUN->TRAIN on any cycle link_active=0: no grant that cycle, train_cnt cleared, rr pointer retained.
REQ-017 RUN arbitration: round-robin over the valid_in bits starting at rr_ptr; the first valid index i gets ready_out_i=1 in the same cycle.
REQ-018 Latency: a granted byte appears on data_out with valid_out=1 and lane_out=i exactly one cycle after ready_out_i=1.
REQ-019 After a grant to i, rr_ptr = (i+1) mod 4 (2-bit wrap); with no grant, rr_ptr is unchanged.
REQ-020 RUN with no valid_in set: next cycle data_out=IDLE_BYTE, valid_out=0, lane_out=0.
REQ-021 Fairness: with all four requesters continuously valid, grants follow the order 0,1,2,3,0,... with no requester skipped; a continuously valid requester waits at most 3 cycles.
REQ-022 ready_out_i SHALL NOT assert when valid_in_i=0, in TRAIN, or during reset.
REQ-023 train_cnt is wide enough for TRAIN_LEN-1 and saturates; it never wraps.

Reset
REQ-024 While reset=1 at a clk_4f edge: state=TRAIN, train_cnt=0, rr_ptr=0, data_out=IDLE_BYTE, valid_out=0, lane_out=0, in_run=0.
REQ-025 Reset asserted in RUN aborts any in-flight byte: the byte granted in the reset cycle is not emitted, and no ready_out asserts in that cycle.
REQ-026 After reset deasserts, the full TRAIN_LEN training sequence is required again before any grant.

Structure
REQ-027 A shared phy package holds IDLE_BYTE (8'hBC), the default TRAIN_LEN, the FSM state encoding, and the lane count (4).
REQ-028 Round-robin selection is a single combinational sub-module rr_select4 (inputs: req[3:0], ptr[1:0]; outputs: gnt[3:0] one-hot, gnt_idx[1:0], any).
REQ-029 The block instantiates alongside the TX parallel-to-serial stage in the PHY top, in behavioural and synthesised-structural forms, with identical cycle behaviour.

Verification
REQ-030 Reset, then link_active=1 with all valid_in=1 -> data_out=0xBC and valid_out=0 for 4 cycles; in_run rises; first valid_out=1 has lane_out=0.
REQ-031 All four valid continuously with data_in_i=8'h10+i -> data_out sequence 10,11,12,13,10 with valid_out=1 each cycle.
REQ-032 Only valid_in2=1 with data 8'hA5 -> ready_out2 every cycle; data_out=A5 with lane_out=2 each cycle; rr_ptr alternates 3 then 3.
REQ-033 link_active drops for 1 cycle mid-RUN -> no grant that cycle; valid_out=0 and data_out=0xBC; 4 more training cycles before the next grant; rr order resumes from the retained pointer.
REQ-034 link_active toggles 1,1,0,1,1,1,1 in TRAIN -> RUN is entered only after the final 4 consecutive high cycles.
REQ-035 Reset pulse in RUN while requester 1 is being granted -> no ready_out in that cycle; outputs at reset values next cycle; TRAIN restarts.

Source files
------------

// File: rtl/phy_tx_lane_scheduler_pkg.sv
// Shared PHY definitions: comma byte, default training length, lane count
// and the scheduler FSM encoding.
package phy_tx_lane_scheduler_pkg;

  localparam logic [7:0] IDLE_BYTE_DEF = 8'hBC;
  localparam int         TRAIN_LEN_DEF = 4;
  localparam int         NUM_LANES     = 4;
  localparam int         LANE_W        = 2;

  typedef enum logic {
    S_TRAIN = 1'b0,
    S_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/phy_tx_lane_scheduler_rr_select4.sv
// Combinational 4-way round-robin selector: the first set request at or
// after ptr (wrapping modulo 4) wins.
module rr_select4
  import phy_tx_lane_scheduler_pkg::*;
(
  input  logic [NUM_LANES-1:0] req,
  input  logic [LANE_W-1:0]    ptr,
  output logic [NUM_LANES-1:0] gnt,
  output logic [LANE_W-1:0]    gnt_idx,
  output logic                 any
);

  // Requests rotated so that position 0 is the lane the pointer names.
  logic [NUM_LANES-1:0] rot_req;
  logic [LANE_W-1:0]    offset;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_rot
      assign rot_req[gi] = req[LANE_W'(ptr + LANE_W'(gi))];
    end
  endgenerate

  // Lowest rotated position wins; scanning downward lets it overwrite last.
  always_comb begin
    offset = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        offset = LANE_W'(k);
      end
    end
  end

  assign any     = |rot_req;
  assign gnt_idx = LANE_W'(ptr + offset);
  assign gnt     = any ? (NUM_LANES'(1) << gnt_idx) : '0;

endmodule

// File: rtl/phy_tx_lane_scheduler.sv
// TX lane scheduler: sends comma bytes while training the link, then
// multiplexes four byte requesters onto one registered byte stream using
// round-robin arbitration.
module phy_tx_lane_scheduler
  import phy_tx_lane_scheduler_pkg::*;
#(
  parameter int         TRAIN_LEN = TRAIN_LEN_DEF,
  parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEF
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       link_active,
  input  logic       valid_in0,
  input  logic       valid_in1,
  input  logic       valid_in2,
  input  logic       valid_in3,
  input  logic [7:0] data_in0,
  input  logic [7:0] data_in1,
  input  logic [7:0] data_in2,
  input  logic [7:0] data_in3,
  output logic       ready_out0,
  output logic       ready_out1,
  output logic       ready_out2,
  output logic       ready_out3,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic [1:0] lane_out,
  output logic       in_run
);

  // Counter only has to reach TRAIN_LEN-1; keep at least one bit.
  localparam int CNT_W = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRAIN_LEN - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  train_cnt_reg, train_cnt_next;
  logic [LANE_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [7:0]        data_out_reg, data_out_next;
  logic              valid_out_reg, valid_out_next;
  logic [LANE_W-1:0] lane_out_reg, lane_out_next;

  logic [NUM_LANES-1:0] valid_vec;
  logic [7:0]           data_arr [NUM_LANES];
  logic [NUM_LANES-1:0] sel_gnt;
  logic [LANE_W-1:0]    sel_idx;
  logic                 sel_any;
  logic                 grant_en;
  logic [NUM_LANES-1:0] ready_vec;

  assign valid_vec   = {valid_in3, valid_in2, valid_in1, valid_in0};
  assign data_arr[0] = data_in0;
  assign data_arr[1] = data_in1;
  assign data_arr[2] = data_in2;
  assign data_arr[3] = data_in3;

  rr_select4 u_rr_select4 (
    .req     (valid_vec),
    .ptr     (rr_ptr_reg),
    .gnt     (sel_gnt),
    .gnt_idx (sel_idx),
    .any     (sel_any)
  );

  // A byte may only be consumed in RUN with the link up and reset low;
  // gating on reset drops whatever would have been granted in that cycle.
  assign grant_en  = (state_reg == S_RUN) && link_active && !reset;
  assign ready_vec = grant_en ? sel_gnt : '0;

  assign ready_out0 = ready_vec[0];
  assign ready_out1 = ready_vec[1];
  assign ready_out2 = ready_vec[2];
  assign ready_out3 = ready_vec[3];

  // Next-state, training counter, pointer and output-byte selection.
  always_comb begin
    state_next     = state_reg;
    train_cnt_next = train_cnt_reg;
    rr_ptr_next    = rr_ptr_reg;
    data_out_next  = IDLE_BYTE;
    valid_out_next = 1'b0;
    lane_out_next  = '0;
    case (state_reg)
      S_TRAIN: begin
        if (!link_active) begin
          train_cnt_next = '0;
        end else if (train_cnt_reg >= CNT_LAST) begin
          state_next     = S_RUN;
          train_cnt_next = '0;
        end else begin
          train_cnt_next = train_cnt_reg + 1'b1;
        end
      end
      S_RUN: begin
        if (!link_active) begin
          // Pointer is deliberately kept so arbitration resumes fairly.
          state_next     = S_TRAIN;
          train_cnt_next = '0;
        end else if (grant_en && sel_any) begin
          data_out_next  = data_arr[sel_idx];
          valid_out_next = 1'b1;
          lane_out_next  = sel_idx;
          rr_ptr_next    = LANE_W'(sel_idx + 1'b1);
        end
      end
      default: begin
        state_next     = S_TRAIN;
        train_cnt_next = '0;
      end
    endcase
  end

  // State and registered outputs, with synchronous reset.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_reg     <= S_TRAIN;
      train_cnt_reg <= '0;
      rr_ptr_reg    <= '0;
      data_out_reg  <= IDLE_BYTE;
      valid_out_reg <= 1'b0;
      lane_out_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      train_cnt_reg <= train_cnt_next;
      rr_ptr_reg    <= rr_ptr_next;
      data_out_reg  <= data_out_next;
      valid_out_reg <= valid_out_next;
      lane_out_reg  <= lane_out_next;
    end
  end

  assign data_out  = data_out_reg;
  assign valid_out = valid_out_reg;
  assign lane_out  = lane_out_reg;
  assign in_run    = (state_reg == S_RUN);

endmodule

// File: tb/tb_phy_tx_lane_scheduler.sv
// Directed bench for the TX lane scheduler: training, round-robin order,
// single requester, link drop, interrupted training and reset in RUN.
module tb_phy_tx_lane_scheduler;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic       link_active;
  logic [3:0] vin;
  logic [7:0] din [4];
  logic       ready_out0, ready_out1, ready_out2, ready_out3;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] lane_out;
  logic       in_run;
  logic [3:0] rdy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_4f = ~clk_4f;

  assign rdy = {ready_out3, ready_out2, ready_out1, ready_out0};

  phy_tx_lane_scheduler #(.TRAIN_LEN(4), .IDLE_BYTE(8'hBC)) dut (
    .clk_4f      (clk_4f),
    .reset       (reset),
    .link_active (link_active),
    .valid_in0   (vin[0]),
    .valid_in1   (vin[1]),
    .valid_in2   (vin[2]),
    .valid_in3   (vin[3]),
    .data_in0    (din[0]),
    .data_in1    (din[1]),
    .data_in2    (din[2]),
    .data_in3    (din[3]),
    .ready_out0  (ready_out0),
    .ready_out1  (ready_out1),
    .ready_out2  (ready_out2),
    .ready_out3  (ready_out3),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .lane_out    (lane_out),
    .in_run      (in_run)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk_4f);
    #1;
  endtask

  // Registered output triple after a clock edge.
  task automatic chk_out(input string tag, input logic [7:0] d, input logic v, input logic [1:0] l);
    chk({tag, "_data"}, 32'(data_out), 32'(d));
    chk({tag, "_valid"}, 32'(valid_out), 32'(v));
    chk({tag, "_lane"}, 32'(lane_out), 32'(l));
  endtask

  // Settle combinational ready after an input change, then compare.
  task automatic chk_rdy(input string tag, input logic [3:0] exp);
    #1;
    chk(tag, 32'(rdy), 32'(exp));
  endtask

  // link_active pattern for the interrupted-training step.
  logic [6:0] link_pat;
  logic [6:0] run_pat;

  initial begin
    reset = 1'b1; link_active = 1'b0; vin = 4'h0;
    for (int i = 0; i < 4; i++) din[i] = 8'h10 + 8'(i);
    tick(); tick();
    $display("reset: data=%0h valid=%0b lane=%0d in_run=%0b", data_out, valid_out, lane_out, in_run);
    chk_out("reset", 8'hBC, 1'b0, 2'd0);
    chk("reset_in_run", 32'(in_run), 32'd0);
    chk("reset_ptr", 32'(dut.rr_ptr_reg), 32'd0);

    // Training with all requesters valid: four comma cycles, no grants.
    reset = 1'b0; link_active = 1'b1; vin = 4'hF;
    for (int k = 0; k < 4; k++) begin
      chk_rdy("train_rdy", 4'h0);
      tick();
      $display("train %0d: data=%0h valid=%0b in_run=%0b", k, data_out, valid_out, in_run);
      chk_out("train", 8'hBC, 1'b0, 2'd0);
      chk("train_in_run", 32'(in_run), (k == 3) ? 32'd1 : 32'd0);
    end

    // All four valid: grants 0,1,2,3,0 with one-cycle latency.
    for (int k = 0; k < 5; k++) begin
      chk_rdy("rr_rdy", 4'(1 << (k % 4)));
      tick();
      $display("rr grant %0d: data=%0h valid=%0b lane=%0d", k, data_out, valid_out, lane_out);
      chk_out("rr", 8'h10 + 8'(k % 4), 1'b1, 2'(k % 4));
    end

    // Only requester 2 valid: granted every cycle, pointer parks at 3.
    vin = 4'b0100; din[2] = 8'hA5;
    for (int k = 0; k < 3; k++) begin
      chk_rdy("solo_rdy", 4'b0100);
      tick();
      $display("solo %0d: data=%0h lane=%0d ptr=%0d", k, data_out, lane_out, dut.rr_ptr_reg);
      chk_out("solo", 8'hA5, 1'b1, 2'd2);
      chk("solo_ptr", 32'(dut.rr_ptr_reg), 32'd3);
    end

    // No requester valid in RUN: comma goes out.
    vin = 4'h0;
    chk_rdy("idle_rdy", 4'h0);
    tick();
    $display("idle: data=%0h valid=%0b lane=%0d", data_out, valid_out, lane_out);
    chk_out("idle", 8'hBC, 1'b0, 2'd0);
    chk("idle_in_run", 32'(in_run), 32'd1);

    // Link drops for one cycle: no grant, retrain, resume from pointer 3.
    din[2] = 8'h12; vin = 4'hF; link_active = 1'b0;
    chk_rdy("drop_rdy", 4'h0);
    tick();
    $display("drop: data=%0h valid=%0b in_run=%0b", data_out, valid_out, in_run);
    chk_out("drop", 8'hBC, 1'b0, 2'd0);
    chk("drop_in_run", 32'(in_run), 32'd0);
    link_active = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_rdy("retrain_rdy", 4'h0);
      tick();
      $display("retrain %0d: valid=%0b in_run=%0b", k, valid_out, in_run);
      chk_out("retrain", 8'hBC, 1'b0, 2'd0);
      chk("retrain_in_run", 32'(in_run), (k == 3) ? 32'd1 : 32'd0);
    end
    chk_rdy("resume_rdy3", 4'b1000);
    tick();
    $display("resume: data=%0h lane=%0d", data_out, lane_out);
    chk_out("resume3", 8'h13, 1'b1, 2'd3);
    chk_rdy("resume_rdy0", 4'b0001);
    tick();
    $display("resume: data=%0h lane=%0d", data_out, lane_out);
    chk_out("resume0", 8'h10, 1'b1, 2'd0);

    // Back to TRAIN, then link 1,1,0,1,1,1,1: RUN only after the last four.
    link_active = 1'b0;
    tick();
    chk("pat_enter_train", 32'(in_run), 32'd0);
    link_pat = 7'b1111011;  // bit k applies to cycle k
    run_pat  = 7'b1000000;
    for (int k = 0; k < 7; k++) begin
      link_active = link_pat[k];
      chk_rdy("pat_rdy", 4'h0);
      tick();
      $display("pattern %0d: link=%0b in_run=%0b valid=%0b", k, link_pat[k], in_run, valid_out);
      chk("pat_in_run", 32'(in_run), 32'(run_pat[k]));
      chk("pat_valid", 32'(valid_out), 32'd0);
    end

    // Requester 1 is being granted (pointer 1) when reset pulses.
    chk_rdy("pre_reset_rdy", 4'b0010);
    reset = 1'b1;
    chk_rdy("reset_run_rdy", 4'h0);
    tick();
    $display("reset in run: data=%0h valid=%0b lane=%0d in_run=%0b", data_out, valid_out, lane_out, in_run);
    chk_out("reset_run", 8'hBC, 1'b0, 2'd0);
    chk("reset_run_in_run", 32'(in_run), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk_rdy("post_reset_rdy", 4'h0);
      tick();
      chk("post_reset_valid", 32'(valid_out), 32'd0);
    end
    chk_rdy("post_reset_grant", 4'b0001);
    tick();
    $display("post reset: data=%0h lane=%0d", data_out, lane_out);
    chk_out("post_reset", 8'h10, 1'b1, 2'd0);

    // Sparse requests 0 and 3 from pointer 1: wrap skips 1 and 2.
    vin = 4'b1001;
    chk_rdy("sparse_rdy3", 4'b1000);
    tick();
    $display("sparse: data=%0h lane=%0d", data_out, lane_out);
    chk_out("sparse3", 8'h13, 1'b1, 2'd3);
    chk_rdy("sparse_rdy0", 4'b0001);
    tick();
    $display("sparse: data=%0h lane=%0d", data_out, lane_out);
    chk_out("sparse0", 8'h10, 1'b1, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
